tanh_pwl_unit: RTL

Pipelined piecewise-linear tanh evaluator for the LSTM activation path. It operates on 12-bit sign-magnitude S1.5.6 operands. Segment selection uses magnitude comparisons of |x| against fixed breakpoints, with ties resolved to the upper segment. The block accepts one operand per cycle over a valid/ready handshake and returns tanh(x) in the same format three register stages later. It feeds the gate multiply stage.

---
 rtl/tanh_pwl_pkg.sv | 29 ++
 rtl/tanh_segment_select.sv | 27 ++
 rtl/tanh_pwl_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/tanh_pwl_pkg.sv
// Shared constants and types for the piecewise-linear tanh evaluator.
// Breakpoints are Q5.6 magnitudes. Slopes and intercepts are Q0.6.
package tanh_pwl_pkg;

    localparam int unsigned WIDTH_DEF     = 12;
    localparam int unsigned FRAC_BITS_DEF = 6;
    localparam int unsigned MAG_W         = 11;
    localparam int unsigned COEF_W        = 6;
    localparam int unsigned NUM_BP        = 5;
    localparam int unsigned PROD_W        = 18;

    typedef logic [2:0] seg_idx_t;

    localparam logic [MAG_W-1:0] BREAKPOINTS [NUM_BP] = '{
        11'h020, 11'h040, 11'h060, 11'h080, 11'h0C0
    };

    localparam seg_idx_t         SEG_SAT = 3'd5;
    localparam logic [MAG_W-1:0] SAT_VAL = 11'd64;

    // Padded to 8 entries so any 3-bit index is in range.
    localparam logic [COEF_W-1:0] SLOPE_TBL [8] = '{
        6'd59, 6'd38, 6'd18, 6'd8, 6'd2, 6'd0, 6'd0, 6'd0
    };
    localparam logic [COEF_W-1:0] INTCPT_TBL [8] = '{
        6'd0, 6'd10, 6'd30, 6'd47, 6'd58, 6'd0, 6'd0, 6'd0
    };

endpackage

// File: rtl/tanh_segment_select.sv
// Combinational segment classifier and coefficient lookup.
// The lookups take separate indices so each pipeline stage can reuse them.
module tanh_segment_select
    import tanh_pwl_pkg::*;
(
    input  logic [MAG_W-1:0]  m,
    output seg_idx_t          seg,
    input  seg_idx_t          slope_idx,
    output logic [COEF_W-1:0] slope,
    input  seg_idx_t          icpt_idx,
    output logic [COEF_W-1:0] intercept
);

    // Ascending breakpoints: the last one met wins, and ties go to the upper segment.
    always_comb begin
        seg = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (m >= BREAKPOINTS[i]) begin
                seg = seg_idx_t'(i + 1);
            end
        end
    end

    assign slope     = SLOPE_TBL[slope_idx];
    assign intercept = INTCPT_TBL[icpt_idx];

endmodule

// File: rtl/tanh_pwl_unit.sv
// Three-stage pipelined piecewise-linear tanh for sign-magnitude S1.5.6 data.
// A single global stall keeps every stage in lockstep, so bubbles are preserved.
module tanh_pwl_unit
    import tanh_pwl_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned SHIFT_W = PROD_W - FRAC_BITS;

    logic                     advance;
    seg_idx_t                 in_seg;
    logic [COEF_W-1:0]        slope;
    logic [COEF_W-1:0]        intercept;

    logic                     s1_valid;
    logic                     s1_sign;
    logic [MAG_W-1:0]         s1_m;
    seg_idx_t                 s1_seg;

    logic                     s2_valid;
    logic                     s2_sign;
    seg_idx_t                 s2_seg;
    logic [SHIFT_W-1:0]       s2_prod;

    logic [PROD_W-1:0]        prod_full;
    logic [SHIFT_W:0]         sum;
    logic [MAG_W-1:0]         res_mag;
    logic [WIDTH-1:0]         res_word;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance && rst_n;

    tanh_segment_select u_sel (
        .m         (in_data[WIDTH-2:0]),
        .seg       (in_seg),
        .slope_idx (s1_seg),
        .slope     (slope),
        .icpt_idx  (s2_seg),
        .intercept (intercept)
    );

    assign prod_full = PROD_W'(s1_m) * PROD_W'(slope);

    always_comb begin
        sum     = {1'b0, s2_prod} + (SHIFT_W + 1)'(intercept);
        res_mag = sum[MAG_W-1:0];
        if (s2_seg == SEG_SAT || sum > (SHIFT_W + 1)'(SAT_VAL)) begin
            res_mag = SAT_VAL;
        end
        // A zero magnitude always carries a positive sign.
        res_word = {s2_sign && (res_mag != '0), res_mag};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_m      <= '0;
            s1_seg    <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_seg    <= '0;
            s2_prod   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_sign   <= in_data[WIDTH-1];
            s1_m      <= in_data[WIDTH-2:0];
            s1_seg    <= in_seg;
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_seg    <= s1_seg;
            s2_prod   <= prod_full[PROD_W-1:FRAC_BITS];
            out_valid <= s2_valid;
            out_data  <= res_word;
        end
    end

endmodule
